// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage controller: FSM states, access sizes,
// MEM/WB bundle field offsets and the alignment rule.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_t;

   localparam int ALU_LSB  = 0;
   localparam int LOAD_LSB = 32;
   localparam int PASS_LSB = 64;

   // The reserved size code behaves like a word, so it needs word alignment too.
   function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return addr_lo[0];
         default: return |addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ready bus between the memory-stage controller (master)
// and the data memory (slave).
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [3:0]        dmem_be;
   logic [31:0]       dmem_wdata;
   logic              dmem_ready;
   logic [31:0]       dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_access_unit_lane_fmt.sv
// Byte-lane steering: store byte enables and data replication, plus load
// lane extraction with sign or zero extension (little-endian lanes).
module mem_lane_fmt
   import mem_access_unit_pkg::*;
(
   input  size_t       size,
   input  logic        sgn,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
   end

   assign byte_sel = lane[addr_lo];
   assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      load_data = rdata;
      case (size)
         SZ_BYTE: load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_data = {{16{sgn & half_sel[15]}}, half_sel};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: runs loads/stores over the dmem handshake, stalls
// upstream while an access is outstanding and builds the MEM/WB bundle.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int PASS_W = 46
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   input  logic                 in_mem_read,
   input  logic                 in_mem_write,
   input  logic [1:0]           in_size,
   input  logic                 in_signed,
   input  logic [ADDR_W-1:0]    in_addr,
   input  logic [31:0]          in_wdata,
   input  logic [PASS_W-1:0]    in_pass,
   mem_access_unit_if.master    dmem,
   output logic                 wb_we,
   output logic [PASS_W+63:0]   wb_bundle,
   output logic                 stall,
   output logic                 misalign_err
);

   localparam int BUNDLE_W = PASS_W + 64;

   state_t              state_reg,  state_next;
   logic [ADDR_W-1:0]   addr_reg,   addr_next;
   size_t               size_reg,   size_next;
   logic                signed_reg, signed_next;
   logic                write_reg,  write_next;
   logic [31:0]         wdata_reg,  wdata_next;
   logic [PASS_W-1:0]   pass_reg,   pass_next;
   logic [31:0]         load_reg,   load_next;

   logic                mem_op;
   logic                misaligned;
   logic                req;
   logic [3:0]          fmt_be;
   logic [31:0]         fmt_wdata;
   logic [31:0]         fmt_load;

   function automatic logic [BUNDLE_W-1:0] pack_bundle(input logic [PASS_W-1:0] p,
                                                       input logic [31:0]       ld,
                                                       input logic [ADDR_W-1:0] a);
      logic [BUNDLE_W-1:0] b;
      b = '0;
      b[PASS_LSB +: PASS_W] = p;
      b[LOAD_LSB +: 32]     = ld;
      b[ALU_LSB +: 32]      = 32'(a);
      return b;
   endfunction

   assign mem_op     = in_valid & (in_mem_read | in_mem_write);
   assign misaligned = is_misaligned(size_t'(in_size), in_addr[1:0]);

   // The formatter works only on latched values so the bus stays stable while BUSY.
   mem_lane_fmt u_lane_fmt (
      .size      (size_reg),
      .sgn       (signed_reg),
      .addr_lo   (addr_reg[1:0]),
      .wdata     (wdata_reg),
      .rdata     (dmem.dmem_rdata),
      .be        (fmt_be),
      .wdata_rep (fmt_wdata),
      .load_data (fmt_load)
   );

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = write_reg;
   assign dmem.dmem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
   assign dmem.dmem_be    = fmt_be;
   assign dmem.dmem_wdata = fmt_wdata;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_reg  <= ST_IDLE;
         addr_reg   <= '0;
         size_reg   <= SZ_BYTE;
         signed_reg <= 1'b0;
         write_reg  <= 1'b0;
         wdata_reg  <= '0;
         pass_reg   <= '0;
         load_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         addr_reg   <= addr_next;
         size_reg   <= size_next;
         signed_reg <= signed_next;
         write_reg  <= write_next;
         wdata_reg  <= wdata_next;
         pass_reg   <= pass_next;
         load_reg   <= load_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      size_next    = size_reg;
      signed_next  = signed_reg;
      write_next   = write_reg;
      wdata_next   = wdata_reg;
      pass_next    = pass_reg;
      load_next    = load_reg;
      req          = 1'b0;
      wb_we        = 1'b0;
      stall        = 1'b0;
      misalign_err = 1'b0;
      wb_bundle    = '0;

      case (state_reg)
         ST_IDLE: begin
            if (!mem_op) begin
               wb_we = 1'b1;
               if (in_valid) wb_bundle = pack_bundle(in_pass, 32'h0, in_addr);
            end else if (misaligned) begin
               // Squash the register write but let the slot retire.
               misalign_err = 1'b1;
               wb_we        = 1'b1;
               wb_bundle    = pack_bundle({in_pass[PASS_W-1:1], 1'b0}, 32'h0, in_addr);
            end else begin
               stall       = 1'b1;
               addr_next   = in_addr;
               size_next   = size_t'(in_size);
               signed_next = in_signed;
               write_next  = in_mem_write;
               wdata_next  = in_wdata;
               pass_next   = in_pass;
               load_next   = '0;
               state_next  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            req   = 1'b1;
            stall = 1'b1;
            if (dmem.dmem_ready) begin
               load_next  = write_reg ? 32'h0 : fmt_load;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            wb_we      = 1'b1;
            wb_bundle  = pack_bundle(pass_reg, load_reg, addr_reg);
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      if (Rst) begin
         req          = 1'b0;
         wb_we        = 1'b0;
         stall        = 1'b0;
         misalign_err = 1'b0;
         wb_bundle    = '0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a scripted data memory.
module tb_mem_access_unit;

   localparam int ADDR_W = 32;
   localparam int PASS_W = 46;

   logic               Clk = 1'b0;
   logic               Rst;
   logic               in_valid, in_mem_read, in_mem_write, in_signed;
   logic [1:0]         in_size;
   logic [31:0]        in_addr, in_wdata;
   logic [PASS_W-1:0]  in_pass;
   logic               wb_we, stall, misalign_err;
   logic [PASS_W+63:0] wb_bundle;

   int checks = 0;
   int errors = 0;
   int wb_cnt;

   mem_access_unit_if #(.ADDR_W(ADDR_W)) dmem_bus ();

   mem_access_unit #(.ADDR_W(ADDR_W), .PASS_W(PASS_W)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .in_valid     (in_valid),
      .in_mem_read  (in_mem_read),
      .in_mem_write (in_mem_write),
      .in_size      (in_size),
      .in_signed    (in_signed),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .in_pass      (in_pass),
      .dmem         (dmem_bus),
      .wb_we        (wb_we),
      .wb_bundle    (wb_bundle),
      .stall        (stall),
      .misalign_err (misalign_err)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200us");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [PASS_W-1:0] p);
      in_valid     = v;
      in_mem_read  = rd;
      in_mem_write = wr;
      in_size      = sz;
      in_signed    = sg;
      in_addr      = a;
      in_wdata     = wd;
      in_pass      = p;
   endtask

   // Accept, one BUSY cycle with immediate ready, then DONE.
   task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic [PASS_W-1:0] p, input logic [31:0] rword,
                         input logic [31:0] exp_load, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd);
      logic [31:0] waddr;
      waddr = {a[31:2], 2'b00};
      tick();
      drive(1'b1, rd, wr, sz, sg, a, wd, p);
      @(negedge Clk);
      chk({tag, "_accept_stall"}, stall, 1'b1);
      chk({tag, "_accept_wbwe"}, wb_we, 1'b0);
      chk({tag, "_accept_req"}, dmem_bus.dmem_req, 1'b0);
      tick();
      dmem_bus.dmem_ready = 1'b1;
      dmem_bus.dmem_rdata = rword;
      @(negedge Clk);
      chk({tag, "_busy_req"}, dmem_bus.dmem_req, 1'b1);
      chk({tag, "_busy_we"}, dmem_bus.dmem_we, wr);
      chk({tag, "_busy_addr"}, dmem_bus.dmem_addr, waddr);
      chk({tag, "_busy_stall"}, stall, 1'b1);
      if (wr) begin
         chk({tag, "_busy_be"}, dmem_bus.dmem_be, exp_be);
         chk({tag, "_busy_wdata"}, dmem_bus.dmem_wdata, exp_wd);
      end
      tick();
      dmem_bus.dmem_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, '0);
      @(negedge Clk);
      chk({tag, "_done_wbwe"}, wb_we, 1'b1);
      chk({tag, "_done_stall"}, stall, 1'b0);
      chk({tag, "_done_req"}, dmem_bus.dmem_req, 1'b0);
      chk({tag, "_done_bundle"}, wb_bundle, {p, exp_load, a});
      $display("txn %s addr=%08h load_data=%08h wb_we=%0b", tag, a, wb_bundle[63:32], wb_we);
   endtask

   initial begin
      Rst = 1'b1;
      dmem_bus.dmem_ready = 1'b0;
      dmem_bus.dmem_rdata = 32'h0;
      // A misaligned load held during reset must not leak through any output.
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 46'h3);
      tick();
      tick();
      @(negedge Clk);
      chk("rst_wbwe", wb_we, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_req", dmem_bus.dmem_req, 1'b0);
      chk("rst_misalign", misalign_err, 1'b0);
      chk("rst_bundle", wb_bundle, '0);
      $display("txn reset");

      tick();
      Rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'hFFFF, 46'h1);
      @(negedge Clk);
      chk("alu_wbwe", wb_we, 1'b1);
      chk("alu_stall", stall, 1'b0);
      chk("alu_req", dmem_bus.dmem_req, 1'b0);
      chk("alu_bundle", wb_bundle, {46'h1, 32'h0, 32'h1234});
      $display("txn alu addr=00001234");

      tick();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h55, 32'h0, 46'h3);
      @(negedge Clk);
      chk("bubble_wbwe", wb_we, 1'b1);
      chk("bubble_bundle", wb_bundle, '0);
      $display("txn bubble");

      run_op("lb", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 46'h2A5,
             32'h80AABBCC, 32'hFFFFFF80, 4'b0000, 32'h0);

      // lhu with three cycles of ready delay.
      tick();
      drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 46'h1C1);
      dmem_bus.dmem_rdata = 32'hFFFFFFFF;
      wb_cnt = 0;
      @(negedge Clk);
      chk("lhu_accept_stall", stall, 1'b1);
      wb_cnt += int'(wb_we);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) begin
            dmem_bus.dmem_ready = 1'b1;
            dmem_bus.dmem_rdata = 32'h9ABC1234;
         end
         @(negedge Clk);
         chk("lhu_req_hold", dmem_bus.dmem_req, 1'b1);
         chk("lhu_addr_hold", dmem_bus.dmem_addr, 32'h100);
         chk("lhu_stall_hold", stall, 1'b1);
         wb_cnt += int'(wb_we);
      end
      tick();
      dmem_bus.dmem_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, '0);
      @(negedge Clk);
      chk("lhu_done_bundle", wb_bundle, {46'h1C1, 32'h00009ABC, 32'h102});
      wb_cnt += int'(wb_we);
      chk("lhu_wbwe_pulses", wb_cnt, 1);
      $display("txn lhu addr=00000102 load_data=%08h", wb_bundle[63:32]);

      run_op("sb", 1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000A5, 46'h0F1,
             32'hDEADBEEF, 32'h0, 4'b0010, 32'hA5A5A5A5);
      run_op("sh_rdwr", 1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 46'h11,
             32'hDEADBEEF, 32'h0, 4'b1100, 32'hBEEFBEEF);
      run_op("sw", 1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 46'h5,
             32'h0, 32'h0, 4'b1111, 32'hCAFEF00D);
      run_op("lh", 1'b1, 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 46'h7,
             32'h7FFF8001, 32'hFFFF8001, 4'b0000, 32'h0);
      run_op("lbu", 1'b1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 46'h9,
             32'h0000F100, 32'h000000F1, 4'b0000, 32'h0);
      run_op("lb_pos", 1'b1, 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 46'h3,
             32'h127F0000, 32'h0000007F, 4'b0000, 32'h0);
      run_op("lw_rsvd", 1'b1, 1'b0, 2'b11, 1'b1, 32'h200, 32'h0, 46'h1F,
             32'h89ABCDEF, 32'h89ABCDEF, 4'b0000, 32'h0);

      tick();
      drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 46'h3);
      @(negedge Clk);
      chk("lw_mis_req", dmem_bus.dmem_req, 1'b0);
      chk("lw_mis_err", misalign_err, 1'b1);
      chk("lw_mis_wbwe", wb_we, 1'b1);
      chk("lw_mis_stall", stall, 1'b0);
      chk("lw_mis_bundle", wb_bundle, {46'h2, 32'h0, 32'h102});
      $display("txn lw_misaligned addr=00000102");

      tick();
      drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h41, 32'h5555, 46'h9);
      @(negedge Clk);
      chk("sh_mis_err", misalign_err, 1'b1);
      chk("sh_mis_req", dmem_bus.dmem_req, 1'b0);
      chk("sh_mis_bundle", wb_bundle, {46'h8, 32'h0, 32'h41});
      $display("txn sh_misaligned addr=00000041");

      tick();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, '0);
      @(negedge Clk);
      chk("mis_pulse_end", misalign_err, 1'b0);
      chk("mis_no_req", dmem_bus.dmem_req, 1'b0);

      // Reset in the middle of an outstanding load.
      tick();
      drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 46'h1);
      @(negedge Clk);
      chk("rstmid_accept_stall", stall, 1'b1);
      tick();
      @(negedge Clk);
      chk("rstmid_busy_req", dmem_bus.dmem_req, 1'b1);
      tick();
      Rst = 1'b1;
      @(negedge Clk);
      chk("rstmid_held_req", dmem_bus.dmem_req, 1'b0);
      chk("rstmid_held_stall", stall, 1'b0);
      chk("rstmid_held_wbwe", wb_we, 1'b0);
      tick();
      Rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, '0);
      @(negedge Clk);
      chk("rstmid_idle_req", dmem_bus.dmem_req, 1'b0);
      chk("rstmid_idle_stall", stall, 1'b0);
      tick();
      dmem_bus.dmem_ready = 1'b1;
      dmem_bus.dmem_rdata = 32'h11223344;
      @(negedge Clk);
      chk("rstmid_late_ready_req", dmem_bus.dmem_req, 1'b0);
      tick();
      dmem_bus.dmem_ready = 1'b0;
      @(negedge Clk);
      chk("rstmid_late_ready_bundle", wb_bundle, '0);
      chk("rstmid_late_ready_stall", stall, 1'b0);
      $display("txn reset_mid_access");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
